// File: rtl/instr_loader_pkg.sv
// ---------------------------------------------------------------------------
// instr_loader_pkg
// Shared definitions for the instruction-RAM program loader:
//   - loader FSM state encoding
//   - bytes per 32-bit word and the width of the byte counter
//   - width of the word counters (image length and write index)
// ---------------------------------------------------------------------------
package instr_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR    = 3'd1,
        ST_DATA   = 3'd2,
        ST_CSUM   = 3'd3,
        ST_VERIFY = 3'd4,
        ST_CHECK  = 3'd5,
        ST_DONE   = 3'd6,
        ST_ERROR  = 3'd7
    } ld_state_e;

    localparam int BYTES_PER_WORD = 4;
    localparam int BCNT_W         = $clog2(BYTES_PER_WORD);

    // Must hold the largest accepted image length (MAX_WORDS) and, during
    // read-back, the index one past the last word.
    localparam int WCNT_W         = 13;

endpackage : instr_loader_pkg

// File: rtl/instr_loader_byte_packer.sv
// ---------------------------------------------------------------------------
// byte_packer
// Assembles four stream bytes into one little-endian 32-bit word (first
// byte lands in bits [7:0]).  word/word_valid are presented combinationally
// in the cycle the fourth byte is accepted, so the consumer can register the
// word on that same clock edge.
//
// Ports:
//   clk        in   1   clock
//   rst_n      in   1   synchronous active-low reset
//   clr        in   1   restart assembly at byte 0 (load start)
//   byte_in    in   8   stream byte
//   byte_valid in   1   byte_in is transferred this cycle
//   word       out  32  assembled word (valid when word_valid)
//   word_valid out  1   one-cycle strobe on the fourth byte
// ---------------------------------------------------------------------------
module byte_packer
    import instr_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [BCNT_W-1:0] cnt_q, cnt_d;
    logic [23:0]       sh_q,  sh_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            sh_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            sh_q  <= sh_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        sh_d  = sh_q;
        if (clr) begin
            cnt_d = '0;
        end else if (byte_valid) begin
            // Newest byte enters at the top; after three bytes sh_q holds
            // {b2, b1, b0} and the fourth byte completes the word.
            sh_d  = {byte_in, sh_q[23:8]};
            cnt_d = cnt_q + BCNT_W'(1);
        end
    end

    assign word       = {byte_in, sh_q};
    assign word_valid = byte_valid && !clr && (cnt_q == BCNT_W'(BYTES_PER_WORD - 1));

endmodule : byte_packer

// File: rtl/instr_loader.sv
// ---------------------------------------------------------------------------
// instr_loader
// Fills the instruction RAM through its port B from a byte stream (usually
// the UART receiver).  Image format, little-endian throughout:
//   4-byte word count N | N data words | 4-byte checksum (XOR of all words)
// Each completed data word is written with a single-cycle web pulse at
// BASE_WADDR + k.  The CPU is held (cpu_hold) while the load is in progress.
//
// Optional feature, macro LOADER_READBACK_VERIFY_EN:
//   after the checksum the loader re-reads all N words over port B and the
//   final comparison uses the XOR of the read-back data instead of the XOR
//   of the received words.  Without the macro doutb is not used.
//
// Parameters:
//   BASE_WADDR  word address of the first image word
//   MAX_WORDS   largest accepted image length in words
//
// Ports:
//   clk       in   1   clock
//   rst_n     in   1   synchronous active-low reset
//   start     in   1   pulse that begins a load (ignored while busy)
//   in_data   in   8   stream byte
//   in_valid  in   1   in_data valid
//   in_ready  out  1   loader accepts a byte this cycle
//   web       out  1   port-B write enable
//   addrb     out  30  port-B word address
//   dinb      out  32  port-B write data
//   doutb     in   32  port-B read data, one cycle after addrb
//   busy      out  1   load in progress
//   cpu_hold  out  1   same as busy
//   done      out  1   load finished with matching checksum (level)
//   error     out  1   bad length or checksum mismatch (level)
// ---------------------------------------------------------------------------
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter logic [29:0] BASE_WADDR = 30'h0,
    parameter int          MAX_WORDS  = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        web,
    output logic [29:0] addrb,
    output logic [31:0] dinb,
    input  logic [31:0] doutb,
    output logic        busy,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    localparam logic [31:0] MAX_WORDS_U = MAX_WORDS;

    ld_state_e         state_q, state_d;
    logic [WCNT_W-1:0] n_q,     n_d;      // image length in words
    logic [WCNT_W-1:0] k_q,     k_d;      // write index / read-back index
    logic [31:0]       acc_q,   acc_d;    // running XOR
    logic [31:0]       exp_q,   exp_d;    // checksum from the stream
    logic              web_q,   web_d;
    logic [29:0]       addrb_q, addrb_d;
    logic [31:0]       dinb_q,  dinb_d;

    logic        start_acc;
    logic        pk_byte_valid;
    logic [31:0] pk_word;
    logic        pk_valid;

    // A start is only honoured when no load is running; it also restarts
    // the byte packer so a partial word from an earlier stream is dropped.
    assign start_acc = start && !busy;

    // Bytes accepted in ERROR are swallowed and never reach the packer.
    assign pk_byte_valid = in_valid && in_ready &&
                           ((state_q == ST_HDR) || (state_q == ST_DATA) ||
                            (state_q == ST_CSUM));

    byte_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (start_acc),
        .byte_in    (in_data),
        .byte_valid (pk_byte_valid),
        .word       (pk_word),
        .word_valid (pk_valid)
    );

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            n_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            exp_q   <= '0;
            web_q   <= 1'b0;
            addrb_q <= BASE_WADDR;
            dinb_q  <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            exp_q   <= exp_d;
            web_q   <= web_d;
            addrb_q <= addrb_d;
            dinb_q  <= dinb_d;
        end
    end

    // ---------------- next-state / datapath ----------------
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        k_d     = k_q;
        acc_d   = acc_q;
        exp_d   = exp_q;
        web_d   = 1'b0;          // write enable is always a single-cycle pulse
        addrb_d = addrb_q;
        dinb_d  = dinb_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d = ST_HDR;
                    k_d     = '0;
                    acc_d   = '0;
                end
            end

            ST_HDR: begin
                if (pk_valid) begin
                    if ((pk_word != 32'd0) && (pk_word <= MAX_WORDS_U)) begin
                        n_d     = WCNT_W'(pk_word);
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_ERROR;
                    end
                end
            end

            ST_DATA: begin
                if (pk_valid) begin
                    web_d   = 1'b1;
                    // 30-bit add: wraps modulo 2^30 past the top of the space
                    addrb_d = BASE_WADDR + 30'(k_q);
                    dinb_d  = pk_word;
                    acc_d   = acc_q ^ pk_word;
                    k_d     = k_q + WCNT_W'(1);
                    if (k_q == n_q - WCNT_W'(1)) begin
                        state_d = ST_CSUM;
                    end
                end
            end

            ST_CSUM: begin
                if (pk_valid) begin
                    exp_d = pk_word;
`ifdef LOADER_READBACK_VERIFY_EN
                    state_d = ST_VERIFY;
                    acc_d   = '0;
                    k_d     = '0;
                    addrb_d = BASE_WADDR;
`else
                    state_d = ST_CHECK;
`endif
                end
            end

`ifdef LOADER_READBACK_VERIFY_EN
            // Cycle k presents address BASE+k; the data for BASE+k-1 arrives
            // on doutb in the same cycle, so cycle 0 has nothing to fold in
            // and cycle N only folds in the last word: N+1 cycles in total.
            ST_VERIFY: begin
                if (k_q != '0) begin
                    acc_d = acc_q ^ doutb;
                end
                if (k_q == n_q) begin
                    state_d = ST_CHECK;
                end else begin
                    k_d     = k_q + WCNT_W'(1);
                    addrb_d = BASE_WADDR + 30'(k_q + WCNT_W'(1));
                end
            end
`endif

            ST_CHECK: begin
                state_d = (acc_q == exp_q) ? ST_DONE : ST_ERROR;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        error    = 1'b0;
        case (state_q)
            ST_HDR, ST_DATA, ST_CSUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            ST_VERIFY, ST_CHECK: busy     = 1'b1;
            ST_DONE:             done     = 1'b1;
            ST_ERROR: begin
                in_ready = 1'b1;
                error    = 1'b1;
            end
            default: ;
        endcase
    end

    assign cpu_hold = busy;
    assign web      = web_q;
    assign addrb    = addrb_q;
    assign dinb     = dinb_q;

`ifndef LOADER_READBACK_VERIFY_EN
    logic unused_doutb;
    assign unused_doutb = ^doutb;
`endif

endmodule : instr_loader
